instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, instruction address width matching the program counter.
REQ-002 The block SHALL have parameter DATA_W, default 32, instruction word width.
REQ-003 The block SHALL have parameter TIMEOUT, default 15, maximum wait cycles for imem_ack (used only with IFETCH_TIMEOUT_EN).
REQ-004 The block SHALL have a single clock domain and an asynchronous, active-high reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  asynchronous active-high reset.
REQ-007 enable  in  1  fetch permitted.
REQ-008 pc  in  ADDR_W  current program counter value.
REQ-009 flush  in  1  discard in-flight/held instruction (branch or PC reset).
REQ-010 pc_inc  out  1  one-cycle pulse requesting the PC advance by one.
REQ-011 imem_rd  out  1  instruction memory read request.
REQ-012 imem_addr  out  ADDR_W  read address.
REQ-013 imem_rdata  in  DATA_W  read data, valid when imem_ack is high.
REQ-014 imem_ack  in  1  read completion, single-cycle pulse.
REQ-015 instr  out  DATA_W  fetched instruction to decoder.
REQ-016 instr_pc  out  ADDR_W  address instr was fetched from.
REQ-017 instr_valid  out  1  instr/instr_pc valid.
REQ-018 instr_ready  in  1  decoder accepts instr.
REQ-019 fetch_err  out  1  sticky fetch timeout flag.

Function
REQ-020 FSM states SHALL be IDLE, REQ, WAIT, HOLD, DROP, ERR.
REQ-021 IDLE: when enable=1, next state REQ; otherwise remain.
REQ-022 REQ: imem_rd=1, imem_addr=pc, address latched internally; next state WAIT.
REQ-023 WAIT: imem_rd held 1 and imem_addr held at latched value until imem_ack; an imem_ack arriving in the REQ cycle SHALL be ignored.
REQ-024 On imem_ack in WAIT: instr<=imem_rdata, instr_pc<=latched address, instr_valid<=1, pc_inc=1 for exactly that cycle, imem_rd<=0, next state HOLD.
REQ-025 HOLD: instr, instr_pc, instr_valid SHALL remain stable until instr_valid&instr_ready; on handshake instr_valid<=0 and next state REQ if enable=1, else IDLE.
REQ-026 Minimum fetch-to-fetch spacing with zero-wait memory (ack in first WAIT cycle) SHALL be 3 cycles.
REQ-027 flush in REQ or WAIT SHALL go to DROP; DROP keeps imem_rd=1 until imem_ack, discards data, emits no pc_inc, then goes to REQ (or IDLE if enable=0).
REQ-028 flush in HOLD SHALL clear instr_valid next cycle, no handshake counted, next state REQ (or IDLE).
REQ-029 flush coincident with imem_ack in WAIT SHALL discard data, no pc_inc, next state REQ.
REQ-030 flush coincident with handshake in HOLD SHALL treat the instruction as consumed; behaviour equals REQ-025.
REQ-031 enable deasserted mid-fetch SHALL not abort; the current instruction completes through HOLD, then IDLE.
REQ-032 Address arithmetic SHALL be performed by the PC block only; pc wrap 8'hFF->8'h00 SHALL need no special handling here.

Reset
REQ-033 reset=1 SHALL immediately force: state IDLE, imem_rd=0, imem_addr=0, instr=0, instr_pc=0, instr_valid=0, pc_inc=0, fetch_err=0, timeout counter=0.
REQ-034 reset mid-WAIT SHALL abandon the read; a later stray imem_ack in IDLE SHALL be ignored.

Configuration
REQ-035 Macro IFETCH_TIMEOUT_EN defined: WAIT/DROP count cycles; TIMEOUT cycles without imem_ack SHALL set fetch_err=1, imem_rd=0, state ERR; ERR exits only by reset.
REQ-036 Macro IFETCH_TIMEOUT_EN undefined: no counter, no ERR entry, fetch_err tied 0, WAIT indefinitely.

Verification
REQ-037 reset, enable=1, pc=8'h00, ack 1 cycle after request with 32'hE3A01005, ready=1 -> instr=32'hE3A01005, instr_pc=0, one pc_inc pulse, next imem_rd 3 cycles later.
REQ-038 instr_ready=0 for 5 cycles in HOLD -> instr/instr_valid stable, no new imem_rd, no extra pc_inc.
REQ-039 flush during WAIT, then ack with 32'hDEADBEEF -> instr_valid stays 0, no pc_inc, new REQ with current pc.
REQ-040 pc=8'hFF fetched then pc=8'h00 -> instr_pc 8'hFF then 8'h00, two pc_inc pulses.
REQ-041 IFETCH_TIMEOUT_EN, TIMEOUT=15, no ack -> fetch_err=1 after 15 WAIT cycles, imem_rd=0; reset clears.
REQ-042 reset asserted mid-WAIT then ack -> all outputs 0, state IDLE, ack ignored.

Source files
------------

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - instruction memory read bus and decoder handoff bundle
//
// Purpose: groups the two handshakes of the fetch unit.
//   imem side : imem_rd / imem_addr (request), imem_rdata / imem_ack (completion pulse)
//   decoder   : instr / instr_pc / instr_valid (offer), instr_ready (accept)
// Modports:
//   master - the fetch unit (drives requests and the decoder offer)
//   slave  - the environment (memory + decoder)
interface instr_fetch_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              imem_rd;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              imem_ack;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;

  modport master (
    output imem_rd, imem_addr, instr, instr_pc, instr_valid,
    input  imem_rdata, imem_ack, instr_ready
  );

  modport slave (
    input  imem_rd, imem_addr, instr, instr_pc, instr_valid,
    output imem_rdata, imem_ack, instr_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - single-outstanding instruction fetch unit
//
// Purpose: issues one instruction memory read at the current pc, holds the
// returned word for the decoder until accepted, and pulses pc_inc once per
// accepted (non-flushed) read. Flush discards an in-flight or held word.
// Ports:
//   clk, reset     - rising-edge clock, asynchronous active-high reset
//   enable         - fetching permitted
//   pc             - current program counter (arithmetic lives in the PC block)
//   flush          - discard in-flight / held instruction
//   pc_inc         - one-cycle pulse: advance pc by one
//   fetch_err      - sticky read-timeout flag
//   bus            - instr_fetch_if.master (imem read bus + decoder handoff)
// Optional feature: define IFETCH_TIMEOUT_EN to enable the imem_ack timeout
// (TIMEOUT cycles in WAIT/DROP without ack -> ERR, left only by reset).
module instr_fetch #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  output logic              pc_inc,
  output logic              fetch_err,
  instr_fetch_if.master     bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    DROP = 3'd4,
    ERR  = 3'd5
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] instr_q;
  logic [ADDR_W-1:0] instr_pc_q;
  logic              valid_q;
  logic              accept;
  logic              handshake;
  logic              timeout_hit;

  // A read is only taken when it completes in WAIT and is not flushed in the
  // same cycle; an ack seen in REQ (or any other state) is ignored.
  assign accept    = (state == WAIT) && bus.imem_ack && !flush;
  assign handshake = valid_q && bus.instr_ready;

`ifdef IFETCH_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;

  // The count covers WAIT and any DROP that follows it, since both are
  // waiting on the same outstanding read.
  assign timeout_hit = ((state == WAIT) || (state == DROP)) && !bus.imem_ack &&
                       (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == REQ) begin
        wait_cnt <= '0;
      end else if (((state == WAIT) || (state == DROP)) && !bus.imem_ack) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign fetch_err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign fetch_err   = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (enable) state_nxt = REQ;
      end
      REQ: begin
        state_nxt = flush ? DROP : WAIT;
      end
      WAIT: begin
        if (timeout_hit) begin
          state_nxt = ERR;
        end else if (bus.imem_ack) begin
          state_nxt = flush ? (enable ? REQ : IDLE) : HOLD;
        end else if (flush) begin
          state_nxt = DROP;
        end
      end
      HOLD: begin
        // A flush coinciding with the handshake still counts as consumed;
        // either way the next step is the same.
        if (handshake || flush) state_nxt = enable ? REQ : IDLE;
      end
      DROP: begin
        if (timeout_hit) begin
          state_nxt = ERR;
        end else if (bus.imem_ack) begin
          state_nxt = enable ? REQ : IDLE;
        end
      end
      ERR: begin
        state_nxt = ERR;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Request outputs follow the state directly so reset clears them at once
  // and the REQ cycle presents the live pc.
  always_comb begin
    bus.imem_rd   = 1'b0;
    bus.imem_addr = '0;
    pc_inc        = accept;
    case (state)
      REQ: begin
        bus.imem_rd   = 1'b1;
        bus.imem_addr = pc;
      end
      WAIT, DROP: begin
        bus.imem_rd   = 1'b1;
        bus.imem_addr = addr_q;
      end
      default: begin
        bus.imem_rd   = 1'b0;
        bus.imem_addr = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q     <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      if (state == REQ) begin
        addr_q <= pc;
      end
      if (accept) begin
        instr_q    <= bus.imem_rdata;
        instr_pc_q <= addr_q;
        valid_q    <= 1'b1;
      end else if ((state == HOLD) && (handshake || flush)) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch
module tb_instr_fetch;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic              flush;
  logic [ADDR_W-1:0] pc;
  logic              pc_inc;
  logic              fetch_err;

  instr_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  instr_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .pc        (pc),
    .flush     (flush),
    .pc_inc    (pc_inc),
    .fetch_err (fetch_err),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0]        mem [256];
  logic [ADDR_W+DATA_W-1:0] sb [$];

  bit                pending;
  bit                dropped;
  bit                stray_ack;
  int                age;
  int                ack_delay;
  logic [ADDR_W-1:0] req_addr;
  int                cyc;
  int                last_req_cyc;
  int                req_gap;
  int                n_req;
  int                pc_inc_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rd"},        bus.imem_rd,     0);
    check({tag, "_addr"},      bus.imem_addr,   0);
    check({tag, "_instr"},     bus.instr,       0);
    check({tag, "_instr_pc"},  bus.instr_pc,    0);
    check({tag, "_valid"},     bus.instr_valid, 0);
    check({tag, "_pc_inc"},    pc_inc,          0);
    check({tag, "_fetch_err"}, fetch_err,       0);
  endtask

  // One clock cycle: memory model, pc_inc / scoreboard checks, then the edge.
  // Entered and left at posedge+1 with this cycle's inputs already driven.
  task automatic run_cycle();
    bit                       ack_now;
    bit                       exp_inc;
    logic [ADDR_W+DATA_W-1:0] e;
    ack_now = 1'b0;
    #1;
    if (reset) begin
      pending = 1'b0;
      dropped = 1'b0;
    end else if (pending) begin
      age++;
      if (ack_delay != 0 && age == ack_delay) ack_now = 1'b1;
    end else if (bus.imem_rd) begin
      pending  = 1'b1;
      dropped  = 1'b0;
      age      = 0;
      req_addr = bus.imem_addr;
      check("req_addr", bus.imem_addr, pc);
      req_gap      = cyc - last_req_cyc;
      last_req_cyc = cyc;
      n_req++;
    end
    bus.imem_ack   = ack_now | stray_ack;
    bus.imem_rdata = ack_now ? mem[req_addr] : (stray_ack ? 32'hBADC0DE5 : 32'h0);
    #1;
    exp_inc = ack_now && !dropped && !flush && !reset;
    check("pc_inc", pc_inc, exp_inc);
    if (pc_inc) pc_inc_cnt++;
    if (exp_inc) sb.push_back({req_addr, mem[req_addr]});
    if (!reset && bus.instr_valid) begin
      check("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0 && (bus.instr_ready || flush)) begin
        e = sb.pop_front();
        if (bus.instr_ready) begin
          check("instr",    bus.instr,    e[DATA_W-1:0]);
          check("instr_pc", bus.instr_pc, e[ADDR_W+DATA_W-1:DATA_W]);
        end
      end
    end
    if (ack_now) pending = 1'b0;
    else if (pending && flush && !reset) dropped = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    bus.imem_ack = 1'b0;
    if (exp_inc) pc = pc + 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while ((pending || bus.instr_valid || bus.imem_rd) && n < 60) begin
      run_cycle();
      n++;
    end
    check("drain_done", pending || bus.instr_valid || bus.imem_rd, 0);
  endtask

  task automatic wait_req(input int target);
    int n = 0;
    while (n_req < target && n < 40) begin
      run_cycle();
      n++;
    end
    check("req_seen", n_req >= target, 1);
  endtask

  initial begin
    int base_inc;
    logic [DATA_W-1:0] held;
    int n;

    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[8'h00] = 32'hE3A01005;
    mem[8'h20] = 32'hDEADBEEF;

    reset = 1'b1; enable = 1'b0; flush = 1'b0; pc = '0;
    bus.instr_ready = 1'b1; bus.imem_ack = 1'b0; bus.imem_rdata = '0;
    stray_ack = 1'b0; pending = 1'b0; dropped = 1'b0; ack_delay = 1;
    cyc = 0; last_req_cyc = -100; n_req = 0; pc_inc_cnt = 0; age = 0; req_gap = 0;
    #1;
    check_zero("reset");
    run_cycle();
    run_cycle();
    check_zero("reset_held");
    reset = 1'b0;

    // zero-wait fetch from 0, back-to-back spacing
    enable = 1'b1; pc = 8'h00; ack_delay = 1;
    wait_req(2);
    check("fetch_gap", req_gap, 3);
    check("first_inc", pc_inc_cnt, 1);
    check("pc_after_first", pc, 8'h01);
    enable = 1'b0;
    drain();

    // decoder stalls 5 cycles in HOLD
    enable = 1'b1; pc = 8'h10; ack_delay = 2; bus.instr_ready = 1'b0;
    n = 0;
    while (!bus.instr_valid && n < 20) begin run_cycle(); n++; end
    check("hold_valid", bus.instr_valid, 1);
    enable = 1'b0;
    held = bus.instr;
    base_inc = pc_inc_cnt;
    for (int i = 0; i < 5; i++) begin
      run_cycle();
      check("stall_valid", bus.instr_valid, 1);
      check("stall_instr", bus.instr, held);
      check("stall_rd", bus.imem_rd, 0);
    end
    check("stall_inc", pc_inc_cnt, base_inc);
    bus.instr_ready = 1'b1;
    drain();

    // flush during WAIT, data discarded, refetch from current pc
    enable = 1'b1; pc = 8'h20; ack_delay = 3;
    base_inc = pc_inc_cnt;
    wait_req(n_req + 1);
    flush = 1'b1;
    run_cycle();
    flush = 1'b0;
    pc = 8'h30;
    n = n_req;
    while (n_req == n && cyc < 5000) begin
      run_cycle();
      check("flush_valid", bus.instr_valid, 0);
    end
    check("flush_no_inc", pc_inc_cnt, base_inc);
    check("refetch_addr", req_addr, 8'h30);
    enable = 1'b0;
    drain();

    // pc wrap FF -> 00
    enable = 1'b1; pc = 8'hFF; ack_delay = 1;
    base_inc = pc_inc_cnt;
    wait_req(n_req + 2);
    enable = 1'b0;
    drain();
    check("wrap_incs", pc_inc_cnt - base_inc, 2);
    check("wrap_pc", pc, 8'h01);

    // enable dropped mid-fetch completes the fetch
    enable = 1'b1; pc = 8'h40; ack_delay = 3;
    base_inc = pc_inc_cnt;
    wait_req(n_req + 1);
    enable = 1'b0;
    drain();
    check("en_drop_inc", pc_inc_cnt - base_inc, 1);

`ifdef IFETCH_TIMEOUT_EN
    enable = 1'b1; pc = 8'h50; ack_delay = 0;
    wait_req(n_req + 1);
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      run_cycle();
      check("to_err_low", fetch_err, 0);
      check("to_rd_high", bus.imem_rd, 1);
    end
    run_cycle();
    check("to_err_set", fetch_err, 1);
    check("to_rd_low", bus.imem_rd, 0);
    run_cycle();
    check("to_err_sticky", fetch_err, 1);
    reset = 1'b1; enable = 1'b0;
    #1;
    check_zero("to_reset");
    run_cycle();
    reset = 1'b0;
`else
    enable = 1'b1; pc = 8'h50; ack_delay = 0;
    wait_req(n_req + 1);
    for (int i = 0; i < TIMEOUT + 5; i++) begin
      run_cycle();
      check("nto_err", fetch_err, 0);
      check("nto_rd", bus.imem_rd, 1);
    end
    reset = 1'b1; enable = 1'b0;
    #1;
    check_zero("nto_reset");
    run_cycle();
    reset = 1'b0;
`endif

    // reset mid-WAIT, then a stray ack in IDLE
    enable = 1'b1; pc = 8'h60; ack_delay = 0;
    wait_req(n_req + 1);
    run_cycle();
    reset = 1'b1; enable = 1'b0;
    #1;
    check_zero("wait_reset");
    run_cycle();
    reset = 1'b0;
    stray_ack = 1'b1;
    run_cycle();
    stray_ack = 1'b0;
    check_zero("stray_ack");
    run_cycle();
    check_zero("stray_after");

    // random traffic
    enable = 1'b1; pc = 8'h80; ack_delay = 1;
    for (int i = 0; i < 400; i++) begin
      bus.instr_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 9) == 0);
      if (flush) pc = 8'($urandom);
      if (!pending) ack_delay = $urandom_range(1, 3);
      enable = ($urandom_range(0, 15) != 0);
      run_cycle();
    end
    flush = 1'b0; enable = 1'b0; bus.instr_ready = 1'b1;
    drain();
    check("sb_drained", sb.size(), 0);
    check("end_err", fetch_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
